decimal_to_xs3gray_encoder: RTL and testbench
=============================================

DECIMAL_TO_XS3GRAY_ENCODER -- requirements
Module: decimal_to_xs3gray_encoder

Interface
REQ-001 SHALL have parameter: STABLE_CYCLES, default 4, consecutive identical samples required to accept a press or a release (legal range 2..15).
REQ-002 SHALL have ports (one clock; reset is synchronous and active-high):
  CLK  input  1  rising-edge clock
  RST  input  1  synchronous active-high reset
  I0..I9  input  1 each  decimal key lines, active-low (0 = digit pressed)
  READY  input  1  consumer accepts code when high with VALID
  D, C, B, A  output  1 each  excess-3 Gray code, D = MSB, registered
  VALID  output  1  code on D..A is stable and valid
  ERR  output  1  multi-key error flag, registered

Function
REQ-003 SHALL register I9..I0 once into I_q before any use; no logic SHALL use raw inputs.
REQ-004 SHALL encode digit n as: 0=0010, 1=0110, 2=0111, 3=0101, 4=0100, 5=1100, 6=1101, 7=1111, 8=1110, 9=1010.
REQ-005 SHALL implement states IDLE, DEBOUNCE, PRESENT, RELEASE with a 4-bit counter cnt.
REQ-006 IDLE: when I_q has an active line -> DEBOUNCE, capture pattern, cnt=1; all inactive -> stay.
REQ-007 DEBOUNCE: I_q equal to captured pattern and cnt==STABLE_CYCLES-1 -> PRESENT, load D..A with code of selected digit, VALID=1; equal and below -> cnt+1; I_q differs and any active -> recapture, cnt=1; all inactive -> IDLE, cnt=0.
REQ-008 Latency: key stable at inputs before edge 0 SHALL give VALID=1 immediately after edge STABLE_CYCLES.
REQ-009 PRESENT: D..A and VALID SHALL hold unchanged regardless of I0..I9 until VALID&&READY is sampled; on that edge -> RELEASE, VALID=0, D..A=0000, cnt=0.
REQ-010 READY while VALID=0 SHALL have no effect.
REQ-011 RELEASE: I_q all inactive -> cnt+1, and on the edge where cnt==STABLE_CYCLES-1 -> IDLE; any active line -> cnt=0, stay in RELEASE (held key SHALL never re-encode).
REQ-012 D..A SHALL be 0000 (not a legal code) whenever VALID=0.
REQ-013 Multiple active lines (macro undefined) SHALL select highest-index digit; pattern comparison in DEBOUNCE uses full 10-bit pattern.

Reset
REQ-014 RST sampled high SHALL set state=IDLE, cnt=0, I_q=all ones, D..A=0000, VALID=0, ERR=0 on that edge, including mid-DEBOUNCE or mid-PRESENT (pending code discarded, no handshake).
REQ-015 RST SHALL take priority over every other event in the same cycle.

Configuration
REQ-016 Macro XS3GRAY_MULTI_ERR_EN: when defined, I_q with more than one active line in IDLE or DEBOUNCE SHALL force IDLE, cnt=0, no code, and ERR=1 for every such cycle (registered, next edge); ERR=0 otherwise.
REQ-017 Without XS3GRAY_MULTI_ERR_EN, ERR SHALL be constant 0 and REQ-013 priority applies.
REQ-018 In PRESENT and RELEASE multiple active lines SHALL never set ERR in either configuration.

Verification
REQ-019 Reset then I3=0 held, READY=1, STABLE_CYCLES=4 -> VALID=1 after edge 4 with DCBA=0101 for one cycle, then VALID=0, DCBA=0000; no second code while I3 held.
REQ-020 I7=0 for 2 cycles then released (bounce), repeated -> VALID never asserts; then I7 held 4 samples -> DCBA=1111.
REQ-021 I5=0 accepted with READY=0 for 10 cycles, I5 released and I9 pressed meanwhile -> DCBA stays 1100, VALID=1 until READY=1, then RELEASE waits for I9 release.
REQ-022 I2=0 and I8=0 together: macro undefined -> DCBA=1110; macro defined -> ERR=1 each cycle, VALID stays 0.
REQ-023 RST=1 one cycle while VALID=1 (DCBA=1010) -> next edge VALID=0, DCBA=0000, ERR=0, state IDLE; key still held re-encodes after STABLE_CYCLES.
REQ-024 Sweep I0..I9 individually with handshake -> DCBA sequence 0010,0110,0111,0101,0100,1100,1101,1111,1110,1010.

Source files
------------

// File: rtl/decimal_to_xs3gray_encoder.sv
// decimal_to_xs3gray_encoder
// Debounced 10-key decimal keypad encoder producing an excess-3 Gray code
// with a VALID/READY handshake.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples to accept a press or a
//                  release (legal range 2..15)
//
// Ports:
//   CLK            rising-edge clock
//   RST            synchronous active-high reset
//   I0..I9         decimal key lines, active-low (0 = pressed)
//   READY          consumer accepts the code when high together with VALID
//   D, C, B, A     registered excess-3 Gray code (D = MSB), 0000 when idle
//   VALID          code on D..A is stable and valid
//   ERR            registered multi-key error flag
//
// Build option:
//   XS3GRAY_MULTI_ERR_EN  when defined, more than one pressed key while
//                         idle or debouncing raises ERR and returns to
//                         IDLE instead of encoding the highest digit.
module decimal_to_xs3gray_encoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic I0,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  input  logic I4,
  input  logic I5,
  input  logic I6,
  input  logic I7,
  input  logic I8,
  input  logic I9,
  input  logic READY,
  output logic D,
  output logic C,
  output logic B,
  output logic A,
  output logic VALID,
  output logic ERR
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESENT  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(STABLE_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [9:0]  i_q;      // registered key lines, active-low
  logic [9:0]  pat_q;    // pattern being debounced
  logic [3:0]  code_q;
  logic        valid_q;
  logic        err_q;

  logic        any_act_s;
  logic        same_s;

  // Highest-index pressed digit of an active-high key vector.
  function automatic logic [3:0] highest_digit(input logic [9:0] act);
    logic [3:0] dig;
    dig = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (act[i]) begin
        dig = 4'(i);
      end
    end
    return dig;
  endfunction

  // Excess-3 Gray code table; non-digits map to the illegal code 0000.
  function automatic logic [3:0] xs3gray(input logic [3:0] dig);
    logic [3:0] code;
    case (dig)
      4'd0:    code = 4'b0010;
      4'd1:    code = 4'b0110;
      4'd2:    code = 4'b0111;
      4'd3:    code = 4'b0101;
      4'd4:    code = 4'b0100;
      4'd5:    code = 4'b1100;
      4'd6:    code = 4'b1101;
      4'd7:    code = 4'b1111;
      4'd8:    code = 4'b1110;
      4'd9:    code = 4'b1010;
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

  assign any_act_s = ~(&i_q);
  assign same_s    = (i_q == pat_q);

`ifdef XS3GRAY_MULTI_ERR_EN
  logic [9:0] act_s;
  logic       multi_s;
  // Clearing the lowest set bit leaves something only if two or more keys are down.
  assign act_s   = ~i_q;
  assign multi_s = ((act_s & (act_s - 10'd1)) != 10'd0);
`endif

  // Input sampling, debounce FSM, handshake and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      i_q     <= 10'h3FF;
      pat_q   <= 10'h3FF;
      code_q  <= 4'b0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      i_q   <= {I9, I8, I7, I6, I5, I4, I3, I2, I1, I0};
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef XS3GRAY_MULTI_ERR_EN
          if (multi_s) begin
            err_q <= 1'b1;
            cnt_q <= 4'd0;
          end else
`endif
          if (any_act_s) begin
            state_q <= DEBOUNCE;
            pat_q   <= i_q;
            cnt_q   <= 4'd1;
          end else begin
            cnt_q <= 4'd0;
          end
        end
        DEBOUNCE: begin
`ifdef XS3GRAY_MULTI_ERR_EN
          if (multi_s) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else
`endif
          if (!any_act_s) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else if (same_s) begin
            if (cnt_q == LAST_CNT) begin
              state_q <= PRESENT;
              code_q  <= xs3gray(highest_digit(~pat_q));
              valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            // Bounce to a different pattern restarts the count on it.
            pat_q <= i_q;
            cnt_q <= 4'd1;
          end
        end
        PRESENT: begin
          // Key lines are ignored here; only the handshake moves on.
          if (READY) begin
            state_q <= RELEASE;
            valid_q <= 1'b0;
            code_q  <= 4'b0000;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q;
          end
        end
        RELEASE: begin
          if (any_act_s) begin
            cnt_q <= 4'd0;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          code_q  <= 4'b0000;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign D     = code_q[3];
  assign C     = code_q[2];
  assign B     = code_q[1];
  assign A     = code_q[0];
  assign VALID = valid_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_decimal_to_xs3gray_encoder.sv
// Testbench for decimal_to_xs3gray_encoder: scoreboard of expected codes,
// popped at each sampled VALID&&READY handshake.
module tb_decimal_to_xs3gray_encoder;

  localparam int SC = 4;

  logic       CLK;
  logic       RST;
  logic [9:0] keys;   // active-low key lines
  logic       READY;
  logic       D, C, B, A, VALID, ERR;

  logic [3:0] exp_q[$];
  logic [3:0] tbl [10] = '{4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                           4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010};
  int total;
  int bad;
  logic seen_valid;
  int n;

  decimal_to_xs3gray_encoder #(.STABLE_CYCLES(SC)) dut (
    .CLK(CLK), .RST(RST),
    .I0(keys[0]), .I1(keys[1]), .I2(keys[2]), .I3(keys[3]), .I4(keys[4]),
    .I5(keys[5]), .I6(keys[6]), .I7(keys[7]), .I8(keys[8]), .I9(keys[9]),
    .READY(READY),
    .D(D), .C(C), .B(B), .A(A), .VALID(VALID), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: handshake decided on pre-edge values, outputs sampled 1 after the edge.
  task automatic tick();
    logic       hs;
    logic [3:0] cap;
    logic [3:0] e;
    hs  = (VALID === 1'b1) && (READY === 1'b1);
    cap = {D, C, B, A};
    @(posedge CLK);
    #1;
    if (hs) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_code", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("code", {28'd0, cap}, {28'd0, e});
      end
    end
    if (VALID === 1'b0) check_eq("idle_zero", {28'd0, D, C, B, A}, 32'd0);
`ifndef XS3GRAY_MULTI_ERR_EN
    check_eq("err_low", {31'd0, ERR}, 32'd0);
`endif
    if (VALID === 1'b1) seen_valid = 1'b1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (VALID !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
    check_eq("valid_seen", {31'd0, VALID}, 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    seen_valid = 1'b0;
    RST   = 1'b1;
    keys  = 10'h3FF;
    READY = 1'b0;
    ticks(2);
    RST = 1'b0;
    check_eq("rst_valid", {31'd0, VALID}, 32'd0);
    check_eq("rst_code", {28'd0, D, C, B, A}, 32'd0);
    check_eq("rst_err", {31'd0, ERR}, 32'd0);
    ticks(2);

    // Held I3 with READY high: one code, exact latency, no repeat while held.
    READY = 1'b1;
    keys = 10'h3FF; keys[3] = 1'b0;
    exp_q.push_back(4'b0101);
    wait_valid(n);
    check_eq("latency", n, SC + 1);
    tick();
    check_eq("after_hs_valid", {31'd0, VALID}, 32'd0);
    seen_valid = 1'b0;
    ticks(12);
    check_eq("held_no_repeat", {31'd0, seen_valid}, 32'd0);
    keys = 10'h3FF;
    ticks(8);

    // Bouncing I7 (2 samples on, 2 off) never reaches VALID.
    seen_valid = 1'b0;
    for (int r = 0; r < 3; r++) begin
      keys[7] = 1'b0; ticks(2);
      keys[7] = 1'b1; ticks(2);
    end
    ticks(3);
    check_eq("bounce_no_valid", {31'd0, seen_valid}, 32'd0);
    keys[7] = 1'b0;
    exp_q.push_back(4'b1111);
    wait_valid(n);
    tick();
    keys = 10'h3FF;
    ticks(8);

    // I5 presented with READY low; code held while keys change underneath.
    READY = 1'b0;
    keys[5] = 1'b0;
    exp_q.push_back(4'b1100);
    wait_valid(n);
    keys = 10'h3FF; keys[9] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold_valid", {31'd0, VALID}, 32'd1);
      check_eq("hold_code", {28'd0, D, C, B, A}, 32'd12);
    end
    READY = 1'b1;
    tick();
    seen_valid = 1'b0;
    ticks(10);
    check_eq("i9_held_no_code", {31'd0, seen_valid}, 32'd0);
    keys = 10'h3FF;
    ticks(8);

    // I2 and I8 together.
    keys[2] = 1'b0; keys[8] = 1'b0;
`ifdef XS3GRAY_MULTI_ERR_EN
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i >= 1) check_eq("multi_err", {31'd0, ERR}, 32'd1);
      check_eq("multi_no_valid", {31'd0, VALID}, 32'd0);
    end
    keys = 10'h3FF;
    ticks(3);
    check_eq("multi_err_clear", {31'd0, ERR}, 32'd0);
`else
    exp_q.push_back(4'b1110);
    wait_valid(n);
    tick();
    keys = 10'h3FF;
`endif
    ticks(8);

    // Reset while presenting I9 discards the code; held key re-encodes.
    READY = 1'b0;
    keys[9] = 1'b0;
    exp_q.push_back(4'b1010);
    wait_valid(n);
    check_eq("pre_rst_code", {28'd0, D, C, B, A}, 32'd10);
    RST = 1'b1;
    tick();
    void'(exp_q.pop_back());
    check_eq("mid_rst_valid", {31'd0, VALID}, 32'd0);
    check_eq("mid_rst_code", {28'd0, D, C, B, A}, 32'd0);
    check_eq("mid_rst_err", {31'd0, ERR}, 32'd0);
    RST = 1'b0;
    exp_q.push_back(4'b1010);
    wait_valid(n);
    check_eq("rst_relatency", n, SC + 1);
    READY = 1'b1;
    tick();
    keys = 10'h3FF;
    ticks(8);

    // Sweep every digit with handshake.
    for (int d = 0; d < 10; d++) begin
      keys = 10'h3FF;
      keys[d] = 1'b0;
      exp_q.push_back(tbl[d]);
      wait_valid(n);
      tick();
      keys = 10'h3FF;
      ticks(8);
    end

    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
